// File: rtl/mac_sequencer.sv
// mac_sequencer: streams len weight/input pairs into Mult and accumulates onto bias with saturation.
// Build option MAC_RELU_EN: clamp a negative final result to 0 (accumulation path unchanged).
module mac_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [31:0]       bias,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [31:0]       w_data,
  input  logic [31:0]       x_data,
  output logic [31:0]       mult_a,
  output logic [31:0]       mult_b,
  input  logic [31:0]       mult_c,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [LEN_W-1:0] len_r, i;
  logic [ADDR_W-1:0] wb, xb;
  logic [31:0] acc, acc_d, sat, res_d;
  logic [32:0] sum;
  logic ovf, ovf_d, sat_f, rd_q, go;
  assign go = state == IDLE && start;
  assign sum = {acc[31], acc} + {mult_c[31], mult_c};
  assign sat_f = sum[32] ^ sum[31];
  assign sat = sat_f ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];
  assign rd_en = state == ISSUE;
  assign w_addr = rd_en ? wb + ADDR_W'(i) : '0;
  assign x_addr = rd_en ? xb + ADDR_W'(i) : '0;
  assign mult_a = rd_q ? w_data : '0;
  assign mult_b = rd_q ? x_data : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef MAC_RELU_EN
  assign res_d = acc_d[31] ? '0 : acc_d;
`else
  assign res_d = acc_d;
`endif
  always_comb begin
    state_d = IDLE;
    acc_d = go ? bias : rd_q ? sat : acc;
    ovf_d = go ? 1'b0 : ovf | (rd_q & sat_f);
    unique case (state)
      IDLE:  state_d = !start ? IDLE : len == '0 ? DONE : ISSUE;
      ISSUE: state_d = i == len_r - LEN_W'(1) ? DRAIN : ISSUE;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      len_r <= '0;
      i <= '0;
      wb <= '0;
      xb <= '0;
      acc <= '0;
      ovf <= 1'b0;
      rd_q <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      acc <= acc_d;
      ovf <= ovf_d;
      rd_q <= rd_en;
      if (go) begin
        len_r <= len;
        wb <= w_base;
        xb <= x_base;
        i <= '0;
      end else if (rd_en) i <= i + LEN_W'(1);
      // result is loaded on entry to DONE so it is valid alongside the done pulse
      if (state_d == DONE) begin
        result <= res_d;
        overflow <= ovf_d;
      end
    end
  end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Dot-product sequencer for the digit-recognition datapath. On `start` it streams `len` weight/input pairs from two synchronous-read memories into the shared signed fixed-point multiplier `Mult`. It accumulates the products onto a bias with saturation and reports the result with a one-cycle `done` pulse. One instance drives one `Mult` instance and is the only block that drives that instance's `a`/`b` operands.

## Interface
Parameters:
- `ADDR_W`, 10: memory address width.
- `LEN_W`, 10: width of the element-count input.

Ports:
- `Clk`, in, 1: system clock, rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin an operation; sampled only in IDLE.
- `len`, in, `LEN_W`: number of elements; 0 is legal.
- `w_base`, in, `ADDR_W`: weight vector base address.
- `x_base`, in, `ADDR_W`: input vector base address.
- `bias`, in, 32: accumulator initial value.
- `rd_en`, out, 1: memory read strobe.
- `w_addr`, out, `ADDR_W`: weight read address.
- `x_addr`, out, `ADDR_W`: input read address.
- `w_data`, in, 32: weight word, valid the cycle after `rd_en`.
- `x_data`, in, 32: input word, valid the cycle after `rd_en`.
- `mult_a`, out, 32: to `Mult.a`.
- `mult_b`, out, 32: to `Mult.b`.
- `mult_c`, in, 32: from `Mult.c`; combinational product.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle completion pulse.
- `result`, out, 32: final accumulator, signed Q8.24.
- `overflow`, out, 1: saturation occurred during the last operation.

## Operation
- All data is signed two's-complement Q8.24, the format of `Mult`. The sequencer does not rescale `mult_c`.
- States:
  - IDLE: `start`=1 latches `len`, `w_base`, `x_base`, loads acc←`bias`, clears `overflow` and index i←0.
    - If `len`≠0 the next state is ISSUE.
    - If `len`=0 the next state is DONE.
  - ISSUE: drive `rd_en`=1, `w_addr`=w_base+i, `x_addr`=x_base+i, then i←i+1. Leave for DRAIN after the cycle with i=len−1.
  - DRAIN: `rd_en`=0; the last product is accumulated. Next state is DONE.
  - DONE: `done`=1 for exactly one cycle, `result` is updated. Next state is IDLE.
- `mult_a`=`w_data` and `mult_b`=`x_data` whenever a read issued in the previous cycle; otherwise both are 0.
- Accumulate on each cycle following an issue cycle:
  - sum = sext33(acc)+sext33(`mult_c`).
  - If sum > 0x7FFFFFFF, acc←0x7FFFFFFF and `overflow`←1.
  - If sum < −2^31, acc←0x80000000 and `overflow`←1.
  - Otherwise acc←sum[31:0].
- Saturation is per step and sticky in `overflow`. Later in-range products may pull a saturated acc back down.
- Address arithmetic wraps modulo 2^`ADDR_W`.
- `start` outside IDLE is ignored; it is not queued.
- Inputs other than `start` are ignored outside the IDLE sampling cycle.
- `result` and `overflow` hold from DONE until the next DONE. They are not cleared by a new `start`.

## Timing
- Cycle 0 is the cycle in which `start` is sampled.
- Element i address is driven in cycle i+1. Its product is added at the end of cycle i+2.
- `done` is high in cycle `len`+2 when `len`≠0, and in cycle 1 when `len`=0. Throughput is one element per cycle.
- `busy`=1 from cycle 1 through the `done` cycle inclusive. A new `start` is accepted in the cycle after `done`.
- Reset values:
  - state IDLE.
  - `busy`, `done`, `rd_en`, `overflow` all 0.
  - `result`, acc, `mult_a`, `mult_b`, `w_addr`, `x_addr` all 0.
- Reset mid-operation aborts in the same edge: no `done` pulse, `result` cleared, `rd_en` low from the next cycle.
- If `Reset` and `start` are both asserted, `Reset` wins.

## Configuration
- `MAC_RELU_EN`
  - Defined: in DONE, `result`←0 if the final acc is negative, otherwise acc. `overflow` is unaffected.
  - Undefined: `result`←acc unmodified.
  - Applies to the output only; the accumulation path is identical either way.

## Test plan
- `len`=1, `bias`=0, w=0x03400000, x=0x02100000 (3.25×2.0625) → `done` in cycle 3, `result`=0x06B40000, `overflow`=0.
- `len`=2, `bias`=0, pairs (0x03400000, 0x02100000) and (0xFCC00000, 0x02100000) → `result`=0x00000000.
- Both polarities of `MAC_RELU_EN`, `len`=1, w=0xFCC00000, x=0x02100000:
  - without the macro → `result`=0xF94C0000.
  - with the macro → `result`=0.
- `len`=4, each pair 0x7F000000×0x01000000 (127×1.0) → `result`=0x7FFFFFFF, `overflow`=1.
- `len`=0, `bias`=0x01000000 → `done` in cycle 1, `result`=0x01000000, `rd_en` never asserted.
- `len`=8, with `start` re-pulsed in cycle 4 and then `Reset` in cycle 6 → second `start` ignored, no `done`, all outputs at reset values from cycle 7, next `start` operates normally.
